// File: rtl/conv1d_mac_ctrl.sv
// rtl/conv1d_mac_ctrl.sv - 1-D convolution MAC sequencer; optional stall counter under CONV_STALL_CNT_EN
module conv1d_mac_ctrl #(
    parameter int N = 43,
    parameter int M = 16,
    parameter int T = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] xmem_addr,
    output logic [$clog2(M)-1:0] fmem_addr,
    output logic                 en_mult_reg,
    output logic                 en_adder_reg,
    output logic                 reset_accum,
    input  logic [T-1:0]         accum_in,
    output logic [T-1:0]         m_data,
    output logic                 m_valid,
    input  logic                 m_ready
`ifdef CONV_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);
    localparam int XW = $clog2(N);
    localparam int FW = $clog2(M);
    localparam logic [FW-1:0] K_LAST = FW'(M - 1);
    localparam logic [XW-1:0] W_LAST = XW'(N - M);

    if (M < 2 || M > N) begin : g_bad_params
        $error("conv1d_mac_ctrl: need 2 <= M <= N");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN   = 3'd2,
        S_CAPTURE = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  w_q, w_d;
    logic [FW-1:0]  k_q, k_d;
    logic           drain_q, drain_d;
    logic           run_d1_q, run_d1_d;
    logic           run_d2_q, run_d2_d;
    logic [T-1:0]   m_data_q, m_data_d;
    logic           done_q, done_d;

    // Next-state: walk the taps of one window, let the MAC settle, capture, then hand off.
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        k_d      = k_q;
        drain_d  = drain_q;
        m_data_d = m_data_q;
        done_d   = 1'b0;
        // Product register lags the address by the memory read; accumulator lags one more.
        run_d1_d = (state_q == S_RUN);
        run_d2_d = run_d1_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    w_d     = '0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_CAPTURE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                m_data_d = accum_in;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (m_ready) begin
                    if (w_q == W_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        w_d     = w_q + 1'b1;
                        k_d     = '0;
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            w_q      <= '0;
            k_q      <= '0;
            drain_q  <= 1'b0;
            run_d1_q <= 1'b0;
            run_d2_q <= 1'b0;
            m_data_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            k_q      <= k_d;
            drain_q  <= drain_d;
            run_d1_q <= run_d1_d;
            run_d2_q <= run_d2_d;
            m_data_q <= m_data_d;
            done_q   <= done_d;
        end
    end

    // Output decode; reset_accum also follows reset so the MAC clears with us.
    always_comb begin
        busy         = (state_q != S_IDLE);
        m_valid      = (state_q == S_OUT);
        reset_accum  = reset || (state_q == S_CAPTURE);
        en_mult_reg  = run_d1_q;
        en_adder_reg = run_d2_q;
        xmem_addr    = w_q + XW'(k_q);
        fmem_addr    = k_q;
        m_data       = m_data_q;
        done         = done_q;
    end

`ifdef CONV_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where the output is offered but not taken.
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
        end else if (state_q == S_OUT && !m_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// tb/tb_conv1d_mac_ctrl.sv - directed self-checking bench for conv1d_mac_ctrl
module tb_conv1d_mac_ctrl;
    localparam int N  = 43;
    localparam int M  = 16;
    localparam int T  = 32;
    localparam int NW = N - M + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 m_ready;
    logic                 busy;
    logic                 done;
    logic [$clog2(N)-1:0] xmem_addr;
    logic [$clog2(M)-1:0] fmem_addr;
    logic                 en_mult_reg;
    logic                 en_adder_reg;
    logic                 reset_accum;
    logic [T-1:0]         accum_in;
    logic [T-1:0]         m_data;
    logic                 m_valid;
`ifdef CONV_STALL_CNT_EN
    logic [31:0]          stall_cycles;
`endif

    always #5 clk = ~clk;

    conv1d_mac_ctrl #(.N(N), .M(M), .T(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .xmem_addr    (xmem_addr),
        .fmem_addr    (fmem_addr),
        .en_mult_reg  (en_mult_reg),
        .en_adder_reg (en_adder_reg),
        .reset_accum  (reset_accum),
        .accum_in     (accum_in),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
`ifdef CONV_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Memories with 1-cycle read plus the single-MAC stage and ReLU.
    logic signed [31:0] xmem [N];
    logic signed [31:0] fmem [M];
    logic signed [31:0] x_rd, f_rd, prod, acc;

    always @(posedge clk) begin
        x_rd <= xmem[xmem_addr];
        f_rd <= fmem[fmem_addr];
        if (reset_accum) begin
            prod <= 0;
            acc  <= 0;
        end else begin
            if (en_mult_reg)  prod <= x_rd * f_rd;
            if (en_adder_reg) acc  <= acc + prod;
        end
    end

    assign accum_in = (acc < 0) ? '0 : acc;

    int tests = 0;
    int fails = 0;
    int n, win_j, ra_cnt, done_cnt, done_n;
    bit hs_now;
    logic [T-1:0] hs_data [$];
    int           hs_n [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expv(input int mode, input int w);
        case (mode)
            0:       return 32'd16;
            1:       return 32'(16 * w + 120);
            default: return 32'd0;
        endcase
    endfunction

    task automatic load(input int mode);
        for (int i = 0; i < N; i++) xmem[i] = (mode == 0) ? 1 : (mode == 1) ? i : 2;
        for (int i = 0; i < M; i++) fmem[i] = (mode == 2) ? -1 : 1;
    endtask

    task automatic cycle();
        hs_now = m_valid && m_ready;
        if (hs_now) begin
            hs_data.push_back(m_data);
            hs_n.push_back(n);
        end
        @(posedge clk);
        #1;
        n++;
        if (hs_now) win_j = 0; else win_j++;
        if (reset_accum) ra_cnt++;
        if (done) begin
            done_cnt++;
            done_n = n;
        end
    endtask

    task automatic run_job(input int mode, input int bp_win, input bit extra, input int abort_win);
        bit bp_done = 0;
        load(mode);
        hs_data.delete();
        hs_n.delete();
        ra_cnt = 0; done_cnt = 0; n = 0;
        m_ready = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        win_j = 0;
        check("busy_after_start", busy, 1);
        for (int c = 0; c < 1200 && done_cnt == 0; c++) begin
            if (abort_win >= 0 && hs_data.size() == abort_win && win_j == M) return;
            if (mode == 1) begin
                if (win_j < M) begin
                    check("xmem_addr", xmem_addr, 32'(hs_data.size() + win_j));
                    check("fmem_addr", fmem_addr, 32'(win_j));
                end
                check("en_mult_reg", en_mult_reg, win_j >= 1 && win_j <= M);
                check("en_adder_reg", en_adder_reg, win_j >= 2 && win_j <= M + 1);
                check("m_valid_phase", m_valid, win_j == M + 3);
            end
            if (m_valid && hs_data.size() == bp_win && !bp_done) begin
                bp_done = 1;
                m_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    check("bp_valid", m_valid, 1);
                    check("bp_data", m_data, expv(mode, bp_win));
                    cycle();
                end
                m_ready = 1'b1;
                check("bp_valid_end", m_valid, 1);
                check("bp_data_end", m_data, expv(mode, bp_win));
                cycle();
                check("next_run_busy", busy, 1);
                check("next_run_valid", m_valid, 0);
                check("next_run_xaddr", xmem_addr, 32'(bp_win + 1));
                continue;
            end
            start = extra && (win_j == 5 || m_valid);
            cycle();
        end
        start = 1'b0;
        check("done_cnt", done_cnt, 1);
        check("n_outputs", hs_data.size(), NW);
        for (int i = 0; i < hs_data.size(); i++) begin
            check("m_data", hs_data[i], expv(mode, i));
            check("hs_time", hs_n[i], 32'(20 * (i + 1) + ((bp_win >= 0 && i >= bp_win) ? 5 : 0)));
        end
        if (hs_n.size() > 0) check("done_time", done_n, 32'(hs_n[hs_n.size() - 1] + 1));
        cycle();
        cycle();
        check("done_once", done_cnt, 1);
        check("idle_busy", busy, 0);
        check("idle_valid", m_valid, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; m_ready = 1'b0;
        n = 0; win_j = 0; ra_cnt = 0; done_cnt = 0; done_n = 0;
        load(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_accum_in_reset", reset_accum, 1);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_xaddr", xmem_addr, 0);
        check("rst_faddr", fmem_addr, 0);
        check("rst_en_mult", en_mult_reg, 0);
        check("rst_en_adder", en_adder_reg, 0);
        check("rst_reset_accum", reset_accum, 0);
`ifdef CONV_STALL_CNT_EN
        check("rst_stall", stall_cycles, 0);
`endif

        run_job(0, -1, 0, -1);
        check("ra_count_basic", ra_cnt, NW);

        run_job(1, -1, 0, -1);

        run_job(2, -1, 0, -1);
        check("ra_count_neg", ra_cnt, NW);

        run_job(0, 3, 0, -1);
`ifdef CONV_STALL_CNT_EN
        check("stall_cycles", stall_cycles, 5);
`endif

        run_job(1, -1, 1, -1);

        run_job(1, -1, 0, 7);
        check("abort_in_drain_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_reset_accum", reset_accum, 1);
        cycle();
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_valid", m_valid, 0);
        check("mid_done", done, 0);
        check("mid_en_mult", en_mult_reg, 0);
        check("mid_en_adder", en_adder_reg, 0);
        check("mid_reset_accum_off", reset_accum, 0);
        check("mid_xaddr", xmem_addr, 0);
        check("mid_data", m_data, 0);
        run_job(1, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
